// File: rtl/tuser_in_fsm.sv
// AXIS-with-tuser splitter: forwards beats through a one-entry skid-free output
// register and peels the first-beat tuser off onto a valid-pulsed tuple port.
module tuser_in_fsm (
  input  logic         tin_aclk,
  input  logic         tin_arst,
  input  logic         tin_avalid,
  output logic         tin_aready,
  input  logic [255:0] tin_adata,
  input  logic [31:0]  tin_akeep,
  input  logic         tin_atlast,
  input  logic [127:0] tin_atuser,
  output logic         tin_bvalid,
  input  logic         tin_bready,
  output logic [255:0] tin_bdata,
  output logic [31:0]  tin_bkeep,
  output logic         tin_btlast,
  output logic         tin_valid,
  output logic [127:0] tin_data,
  output logic [15:0]  dbg_pkt_cnt,
  output logic [0:2]   dbg_state
);

  typedef enum logic [2:0] {
    WAIT_SOP = 3'b000,
    IN_PKT   = 3'b001
  } state_t;

  typedef struct packed {
    logic [255:0] data;
    logic [31:0]  keep;
    logic         last;
  } beat_t;

  state_t       state_q, state_d;
  beat_t        beat_q, beat_d;
  logic         bvalid_q, bvalid_d;
  logic         tvalid_q, tvalid_d;
  logic [127:0] tdata_q, tdata_d;
  logic [15:0]  pkt_cnt_q, pkt_cnt_d;
  logic         hs;

  // The register can take a new beat when empty or being drained this cycle.
  assign tin_aready = (!bvalid_q || tin_bready) && !tin_arst;
  assign hs         = tin_avalid && tin_aready;

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    bvalid_d  = bvalid_q;
    tvalid_d  = 1'b0;
    tdata_d   = tdata_q;
    pkt_cnt_d = pkt_cnt_q;
    if (hs) begin
      beat_d   = '{data: tin_adata, keep: tin_akeep, last: tin_atlast};
      bvalid_d = 1'b1;
      if (tin_atlast) pkt_cnt_d = pkt_cnt_q + 16'd1;
      case (state_q)
        WAIT_SOP: begin
          // tvalid is registered so it lines up with the first beat's bvalid.
          tdata_d  = tin_atuser;
          tvalid_d = 1'b1;
          state_d  = tin_atlast ? WAIT_SOP : IN_PKT;
        end
        IN_PKT:   state_d = tin_atlast ? WAIT_SOP : IN_PKT;
        default:  state_d = WAIT_SOP;
      endcase
    end else if (tin_bready) begin
      bvalid_d = 1'b0;
    end
  end

  always_ff @(posedge tin_aclk) begin
    if (tin_arst) begin
      state_q   <= WAIT_SOP;
      beat_q    <= '0;
      bvalid_q  <= 1'b0;
      tvalid_q  <= 1'b0;
      tdata_q   <= '0;
      pkt_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      bvalid_q  <= bvalid_d;
      tvalid_q  <= tvalid_d;
      tdata_q   <= tdata_d;
      pkt_cnt_q <= pkt_cnt_d;
    end
  end

  assign tin_bvalid  = bvalid_q;
  assign tin_bdata   = beat_q.data;
  assign tin_bkeep   = beat_q.keep;
  assign tin_btlast  = beat_q.last;
  assign tin_valid   = tvalid_q;
  assign tin_data    = tdata_q;
  assign dbg_pkt_cnt = pkt_cnt_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_tuser_in_fsm.sv
// Scoreboard bench for tuser_in_fsm: accepted beats are queued by a packet-level
// model and a negedge monitor compares every presented output against the queue.
module tb_tuser_in_fsm;

  logic         tin_aclk = 1'b0;
  logic         tin_arst;
  logic         tin_avalid;
  logic         tin_aready;
  logic [255:0] tin_adata;
  logic [31:0]  tin_akeep;
  logic         tin_atlast;
  logic [127:0] tin_atuser;
  logic         tin_bvalid;
  logic         tin_bready;
  logic [255:0] tin_bdata;
  logic [31:0]  tin_bkeep;
  logic         tin_btlast;
  logic         tin_valid;
  logic [127:0] tin_data;
  logic [15:0]  dbg_pkt_cnt;
  logic [0:2]   dbg_state;

  tuser_in_fsm dut (
    .tin_aclk(tin_aclk), .tin_arst(tin_arst),
    .tin_avalid(tin_avalid), .tin_aready(tin_aready),
    .tin_adata(tin_adata), .tin_akeep(tin_akeep), .tin_atlast(tin_atlast),
    .tin_atuser(tin_atuser),
    .tin_bvalid(tin_bvalid), .tin_bready(tin_bready),
    .tin_bdata(tin_bdata), .tin_bkeep(tin_bkeep), .tin_btlast(tin_btlast),
    .tin_valid(tin_valid), .tin_data(tin_data),
    .dbg_pkt_cnt(dbg_pkt_cnt), .dbg_state(dbg_state)
  );

  always #5 tin_aclk = ~tin_aclk;

  typedef struct {
    logic [255:0] d;
    logic [31:0]  k;
    logic         l;
    logic         sop;
    logic [127:0] u;
  } exp_beat_t;

  int n_chk  = 0;
  int n_fail = 0;
  bit mon_on = 1'b0;
  int bready_mode = 0;  // 0: always ready, 1: random, 2: stalled

  // Packet-level reference state
  exp_beat_t    sb_q[$];
  bit           shown = 1'b0;
  bit           at_sop = 1'b1;
  logic [15:0]  m_cnt = '0;
  logic [127:0] m_tuple = '0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Output ready pattern, changed just after each rising edge
  initial begin
    tin_bready = 1'b1;
    forever begin
      @(posedge tin_aclk); #1;
      case (bready_mode)
        0: tin_bready = 1'b1;
        1: tin_bready = ($urandom_range(99) < 65);
        default: tin_bready = 1'b0;
      endcase
    end
  end

  // Monitor + model: compares current outputs, then advances the model for the coming edge
  always @(negedge tin_aclk) begin
    if (mon_on) begin
      logic exp_ar;
      chk("bvalid", 256'(tin_bvalid), 256'(sb_q.size() != 0));
      if (sb_q.size() != 0) begin
        chk("bdata", tin_bdata, sb_q[0].d);
        chk("bkeep", 256'(tin_bkeep), 256'(sb_q[0].k));
        chk("btlast", 256'(tin_btlast), 256'(sb_q[0].l));
        chk("tvalid", 256'(tin_valid), 256'(sb_q[0].sop && !shown));
      end else begin
        chk("tvalid_idle", 256'(tin_valid), 256'(0));
      end
      chk("tdata", 256'(tin_data), 256'(m_tuple));
      chk("pkt_cnt", 256'(dbg_pkt_cnt), 256'(m_cnt));
      chk("state", 256'(dbg_state), 256'(at_sop ? 3'b000 : 3'b001));
      exp_ar = (sb_q.size() == 0 || tin_bready) && !tin_arst;
      chk("aready", 256'(tin_aready), 256'(exp_ar));
      if (sb_q.size() != 0) begin
        if (tin_bready) begin
          void'(sb_q.pop_front());
          shown = 1'b0;
        end else begin
          shown = 1'b1;
        end
      end
      if (tin_arst) begin
        sb_q.delete();
        shown = 1'b0; at_sop = 1'b1; m_cnt = '0; m_tuple = '0;
      end else if (tin_avalid && exp_ar) begin
        sb_q.push_back('{d: tin_adata, k: tin_akeep, l: tin_atlast, sop: at_sop, u: tin_atuser});
        if (at_sop) m_tuple = tin_atuser;
        at_sop = tin_atlast;
        if (tin_atlast) m_cnt = m_cnt + 16'd1;
      end
    end
  end

  // Sends the first nbeats beats of a len-beat packet; gap is the percent idle chance
  task automatic send_pkt(input int len, input int nbeats, input int gap,
                          input logic [127:0] u0, input bit fixed);
    for (int b = 0; b < nbeats; b++) begin
      bit acc = 1'b0;
      int budget = 0;
      tin_adata  = fixed ? 256'h22222 : {8{$urandom}};
      tin_akeep  = fixed ? 32'h33333 : (($urandom_range(7) == 0) ? 32'h0 : $urandom);
      tin_atlast = (b == len - 1);
      tin_atuser = (b == 0) ? u0 : {4{$urandom}};
      tin_avalid = 1'b0;
      while (!acc) begin
        if (!tin_avalid) tin_avalid = ($urandom_range(99) >= gap);
        @(negedge tin_aclk);
        acc = tin_avalid && tin_aready;
        @(posedge tin_aclk); #1;
        if (++budget > 2000) begin
          n_chk++; n_fail++;
          $display("FAIL accept_timeout: beat %0d not accepted within 2000 cycles", b);
          acc = 1'b1;
        end
      end
      tin_avalid = 1'b0;
    end
  endtask

  task automatic do_reset(input int n);
    tin_arst = 1'b1;
    tin_avalid = 1'b0;
    repeat (n) begin
      @(posedge tin_aclk); #1;
      mon_on = 1'b1;
      chk("aready_in_reset", 256'(tin_aready), 256'(0));
    end
    tin_arst = 1'b0;
    chk("rst_bvalid", 256'(tin_bvalid), 256'(0));
    chk("rst_tvalid", 256'(tin_valid), 256'(0));
    chk("rst_bdata", tin_bdata, 256'(0));
    chk("rst_bkeep", 256'(tin_bkeep), 256'(0));
    chk("rst_btlast", 256'(tin_btlast), 256'(0));
    chk("rst_tdata", 256'(tin_data), 256'(0));
    chk("rst_cnt", 256'(dbg_pkt_cnt), 256'(0));
    chk("rst_state", 256'(dbg_state), 256'(0));
  endtask

  initial begin
    tin_arst = 1'b1; tin_avalid = 1'b0; tin_adata = '0; tin_akeep = '0;
    tin_atlast = 1'b0; tin_atuser = '0;
    do_reset(2);

    // 3-beat packet, fixed payload, full rate
    send_pkt(3, 3, 0, 128'h44444, 1'b1);
    repeat (3) @(posedge tin_aclk); #1;
    chk("pkt3_cnt", 256'(dbg_pkt_cnt), 256'(1));
    chk("pkt3_tuple", 256'(tin_data), 256'(128'h44444));

    // Output stall mid-packet
    fork
      send_pkt(6, 6, 0, {4{$urandom}}, 1'b0);
      begin
        repeat (2) @(posedge tin_aclk); #1;
        bready_mode = 2;
        repeat (4) @(posedge tin_aclk); #1;
        bready_mode = 0;
      end
    join

    // Back-to-back single-beat packets
    for (int i = 1; i <= 3; i++) send_pkt(1, 1, 0, 128'(i), 1'b0);
    repeat (3) @(posedge tin_aclk); #1;
    chk("single_cnt", 256'(dbg_pkt_cnt), 256'(5));
    chk("single_tuple", 256'(tin_data), 256'(3));

    // Reset after beat 2 of a 4-beat packet, then a fresh packet
    send_pkt(4, 2, 0, {4{$urandom}}, 1'b0);
    do_reset(1);
    send_pkt(2, 2, 0, 128'h5555, 1'b0);
    repeat (3) @(posedge tin_aclk); #1;
    chk("post_rst_tuple", 256'(tin_data), 256'(128'h5555));

    // Random traffic with random output stalls
    bready_mode = 1;
    for (int p = 0; p < 40; p++) begin
      int len = $urandom_range(1, 6);
      send_pkt(len, len, 30, {4{$urandom}}, 1'b0);
    end
    bready_mode = 0;
    repeat (4) @(posedge tin_aclk); #1;

    // Counter wrap
    do_reset(1);
    for (int p = 0; p < 65536; p++) send_pkt(1, 1, 0, {4{$urandom}}, 1'b0);
    repeat (3) @(posedge tin_aclk); #1;
    chk("cnt_wrap", 256'(dbg_pkt_cnt), 256'(0));
    chk("drained", 256'(sb_q.size()), 256'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/tuser_in_fsm.md
TUSER_IN_FSM -- requirements
Module: tuser_in_fsm

Interface
REQ-001 The block SHALL have the port tin_aclk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-002 The block SHALL have the port tin_arst, input, 1 bit, the reset; it is synchronous and active-high.
REQ-003 The block SHALL have the port tin_avalid, input, 1 bit, the input AXIS beat valid.
REQ-004 The block SHALL have the port tin_aready, output, 1 bit, the input AXIS ready.
REQ-005 The block SHALL have the port tin_adata, input, 256 bits, the input beat data.
REQ-006 The block SHALL have the port tin_akeep, input, 32 bits, the input byte enables.
REQ-007 The block SHALL have the port tin_atlast, input, 1 bit, the input last beat of packet.
REQ-008 The block SHALL have the port tin_atuser, input, 128 bits, the input per-packet metadata; it is meaningful on the first beat only.
REQ-009 The block SHALL have the port tin_bvalid, output, 1 bit, the output AXIS beat valid.
REQ-010 The block SHALL have the port tin_bready, input, 1 bit, the output AXIS ready.
REQ-011 The block SHALL have the ports tin_bdata, tin_bkeep and tin_btlast, outputs, 256, 32 and 1 bits, the output beat data, keep and last.
REQ-012 The block SHALL have the port tin_valid, output, 1 bit, the tuple valid pulse.
REQ-013 The block SHALL have the port tin_data, output, 128 bits, the extracted tuple.
REQ-014 The block SHALL have the port dbg_pkt_cnt, output, 16 bits, the count of completed packets.
REQ-015 The block SHALL have the port dbg_state, output, bits [0:2], the FSM state encoding.

Function
REQ-016 The block SHALL split a tuser-carrying AXIS stream into a plain AXIS stream plus a tuple interface; this is the inverse of tuser_out_fsm.
REQ-017 A handshake SHALL occur on a cycle where tin_avalid=1 and tin_aready=1.
REQ-018 The block SHALL contain a one-entry output register holding bdata, bkeep and btlast, with tin_bvalid as its occupancy flag.
REQ-019 tin_aready SHALL equal (!tin_bvalid || tin_bready) && !tin_arst, and SHALL be combinational.
REQ-020 On a handshake the beat SHALL be loaded into the output register, and tin_bvalid=1 on the next cycle; the latency is 1 cycle.
REQ-021 If the output register is occupied, tin_bready=1 and no handshake occurs, tin_bvalid SHALL go to 0 on the next cycle.
REQ-022 While tin_bvalid=1 and tin_bready=0, the output register SHALL hold and tin_aready SHALL be 0.
REQ-023 Simultaneous drain and load SHALL give full throughput: one beat per cycle, with no bubble.
REQ-024 The FSM SHALL have two states: WAIT_SOP (dbg_state=3'b000) and IN_PKT (3'b001).
REQ-025 WAIT_SOP: a handshake with tin_atlast=0 SHALL move the FSM to IN_PKT.
REQ-026 WAIT_SOP: a handshake with tin_atlast=1 (single-beat packet) SHALL leave the FSM in WAIT_SOP.
REQ-027 IN_PKT: a handshake with tin_atlast=1 SHALL move the FSM to WAIT_SOP; otherwise the FSM SHALL stay in IN_PKT.
REQ-028 In WAIT_SOP, a handshake SHALL capture tin_atuser into tin_data.
REQ-029 tin_valid SHALL be 1 for exactly one cycle, the same cycle the first beat first appears with tin_bvalid=1.
REQ-030 tin_valid SHALL NOT be gated by tin_bready, because the tuple consumer has no backpressure.
REQ-031 tin_data SHALL hold its value until the next first-beat capture.
REQ-032 tin_atuser on non-first beats SHALL be ignored.
REQ-033 dbg_pkt_cnt SHALL increment by 1 on every handshake with tin_atlast=1, and SHALL wrap from 16'hFFFF to 0.
REQ-034 Input beats presented while tin_aready=0 SHALL be neither consumed nor reflected on any output.
REQ-035 tin_akeep SHALL be passed through unmodified, and all-zero keep SHALL be forwarded as-is.

Reset
REQ-036 While tin_arst=1 at a clock edge, the block SHALL set the state to WAIT_SOP and clear tin_bvalid, tin_valid, tin_bdata, tin_bkeep, tin_btlast, tin_data and dbg_pkt_cnt to 0.
REQ-037 tin_aready SHALL be 0 for the whole time tin_arst=1.
REQ-038 A reset mid-packet SHALL discard the held beat.
REQ-039 After reset, the next accepted beat SHALL be treated as a first beat; upstream is reset together with this block.
REQ-040 The first handshake SHALL be possible on the first cycle after tin_arst deasserts.

Verification
REQ-041 Scenario (reset): assert tin_arst for 2 cycles -> all outputs are 0, tin_aready=0, dbg_state=000.
REQ-042 Scenario (3-beat packet): atuser=44444 on beat 1, data=22222, keep=33333, tlast on beat 3, bready=1 -> 3 output beats at 1-cycle latency, back-to-back; tin_valid high only alongside output beat 1; tin_data=44444; dbg_pkt_cnt=1; tuser on beats 2-3 is ignored.
REQ-043 Scenario (backpressure): bready=0 for 4 cycles mid-packet -> tin_aready=0, the output beat is held stable, no beat is lost or duplicated, and the stream resumes when bready=1.
REQ-044 Scenario (single-beat packets): single-beat packets back-to-back with tuser 1, 2, 3 -> three tin_valid pulses with tin_data 1, 2, 3; the state stays 000; dbg_pkt_cnt=3.
REQ-045 Scenario (reset mid-packet): tin_arst after beat 2 of a 4-beat packet -> tin_bvalid=0; the next beat's tuser is captured as a new tuple.
REQ-046 Scenario (counter wrap): preload via 65536 packets -> dbg_pkt_cnt wraps to 0.
